// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// XLEN is the datapath width; NOP_INSTR is the bubble word (addi x0,x0,0).
package fetch_stage_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StHold = 2'd2,
        StDrop = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if_id_register.sv
// IF/ID pipeline register.
// Update priority, highest first: flush, stall, load, bubble.
module fetch_stage_if_id_register
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] NopInstr = NOP_INSTR
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush_i,
    input  logic            stall_i,
    input  logic            load_i,
    input  logic [XLEN-1:0] load_pc_i,
    input  logic [XLEN-1:0] load_instr_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] instr_o,
    output logic            valid_o
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic            valid_q, valid_d;

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        if (flush_i) begin
            pc_d    = '0;
            instr_d = NopInstr;
            valid_d = 1'b0;
        end else if (!stall_i) begin
            if (load_i) begin
                pc_d    = load_pc_i;
                instr_d = load_instr_i;
                valid_d = 1'b1;
            end else begin
                // Decode consumed the entry and nothing new arrived; pc is left as is.
                instr_d = NopInstr;
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q    <= '0;
            instr_q <= NopInstr;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign pc_o    = pc_q;
    assign instr_o = instr_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: single-outstanding imem request, hold buffer for decode
// back-pressure, response-drop after flush and a sticky response-timeout flag.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] NopInstr = NOP_INSTR,
    parameter int unsigned     Timeout  = 64
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_i,
    input  logic            flush_i,
    input  logic            id_stall_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_valid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            fetch_stall_o,
    output logic [XLEN-1:0] if_id_pc_o,
    output logic [XLEN-1:0] if_id_instr_o,
    output logic            if_id_valid_o,
    output logic            fetch_fault_o
);

    localparam int unsigned CntW = $clog2(Timeout + 1);

    fetch_state_e    state_q, state_d;
    logic            req_q, req_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] buf_q, buf_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            fault_q, fault_d;

    logic            issue;
    logic            load;
    logic [XLEN-1:0] load_instr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (!flush_i) state_d = StWait;
            StWait: begin
                if (imem_valid_i) begin
                    state_d = (flush_i || !id_stall_i) ? StIdle : StHold;
                end else if (flush_i) begin
                    state_d = StDrop;
                end
            end
            StHold: if (flush_i || !id_stall_i) state_d = StIdle;
            // A flush here is moot: the in-flight word is already condemned.
            StDrop: if (imem_valid_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        issue      = (state_q == StIdle) && !flush_i;
        load       = !flush_i && !id_stall_i &&
                     (((state_q == StWait) && imem_valid_i) || (state_q == StHold));
        load_instr = (state_q == StHold) ? buf_q : imem_rdata_i;

        req_d  = issue;
        addr_d = issue ? pc_i : addr_q;
        buf_d  = buf_q;
        if ((state_q == StWait) && imem_valid_i && !flush_i && id_stall_i) begin
            buf_d = imem_rdata_i;
        end

        cnt_d = cnt_q;
        if (issue) begin
            cnt_d = '0;
        end else if ((state_q == StWait) && (cnt_q != CntW'(Timeout))) begin
            cnt_d = cnt_q + CntW'(1);
        end
        // Rises on the edge that closes the Timeout-th WAIT cycle.
        fault_d = fault_q | ((state_q == StWait) && (cnt_q >= CntW'(Timeout - 1)));

        fetch_stall_o = (state_q != StIdle);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            req_q   <= 1'b0;
            addr_q  <= '0;
            buf_q   <= '0;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            req_q   <= req_d;
            addr_q  <= addr_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    assign imem_req_o    = req_q;
    assign imem_addr_o   = addr_q;
    assign fetch_fault_o = fault_q;

    fetch_stage_if_id_register #(
        .NopInstr(NopInstr)
    ) u_if_id (
        .clock       (clock),
        .reset       (reset),
        .flush_i     (flush_i),
        .stall_i     (id_stall_i),
        .load_i      (load),
        .load_pc_i   (addr_q),
        .load_instr_i(load_instr),
        .pc_o        (if_id_pc_o),
        .instr_o     (if_id_instr_o),
        .valid_o     (if_id_valid_o)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: PC driver, latency-programmable memory, and a transaction
// model whose predicted IF/ID entries are queued and compared as decode consumes them.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    localparam int unsigned TIMEOUT = 8;

    logic        clock;
    logic        reset;
    logic [31:0] pc_i;
    logic        flush_i;
    logic        id_stall_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_valid_i;
    logic [31:0] imem_rdata_i;
    logic        fetch_stall_o;
    logic [31:0] if_id_pc_o;
    logic [31:0] if_id_instr_o;
    logic        if_id_valid_o;
    logic        fetch_fault_o;

    fetch_stage #(
        .NopInstr(NOP_INSTR),
        .Timeout (TIMEOUT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .pc_i         (pc_i),
        .flush_i      (flush_i),
        .id_stall_i   (id_stall_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_valid_i (imem_valid_i),
        .imem_rdata_i (imem_rdata_i),
        .fetch_stall_o(fetch_stall_o),
        .if_id_pc_o   (if_id_pc_o),
        .if_id_instr_o(if_id_instr_o),
        .if_id_valid_o(if_id_valid_o),
        .fetch_fault_o(fetch_fault_o)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifid_t;

    ifid_t exp_q[$];
    int    n_run;
    int    n_fail;

    // Stimulus controls, written by the main sequence only.
    logic [31:0] start_pc;
    logic [31:0] br_pc;
    int          mem_lat;
    logic        end_req;

    // Transaction model, written by the monitor only.
    logic        t_act, t_resp, t_kill;
    logic [31:0] t_pc;
    int          t_age, wc;
    logic        f_exp, flush_prev, pc_adv, pc_br;

    // Memory model state.
    logic        m_pend;
    int          m_cnt;
    logic [31:0] m_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h0010_0093;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Advance to the first cycle in which a request pulse is visible (bounded).
    task automatic wait_req();
        for (int i = 0; i < 20; i++) begin
            cycles(1);
            if (imem_req_o) break;
        end
    endtask

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Memory: responds mem_lat-1 cycles after the request cycle; mem_lat==0 never responds.
    initial begin
        imem_valid_i = 1'b0;
        imem_rdata_i = '0;
        m_pend       = 1'b0;
        m_cnt        = 0;
        m_addr       = '0;
        forever begin
            @(posedge clock);
            #2;
            imem_valid_i = 1'b0;
            if (reset) begin
                m_pend = 1'b0;
            end else begin
                if (imem_req_o && mem_lat != 0) begin
                    m_pend = 1'b1;
                    m_cnt  = mem_lat - 1;
                    m_addr = imem_addr_o;
                end
                if (m_pend) begin
                    if (m_cnt == 0) begin
                        imem_valid_i = 1'b1;
                        imem_rdata_i = mem_word(m_addr);
                        m_pend       = 1'b0;
                    end else begin
                        m_cnt--;
                    end
                end
            end
        end
    end

    // Monitor: drives the PC, checks every cycle, predicts the next edge.
    initial begin
        n_run      = 0;
        n_fail     = 0;
        pc_i       = 32'h003F_FFFC;
        t_act      = 1'b0;
        t_resp     = 1'b0;
        t_kill     = 1'b0;
        t_pc       = '0;
        t_age      = 0;
        wc         = 0;
        f_exp      = 1'b0;
        flush_prev = 1'b0;
        pc_adv     = 1'b0;
        pc_br      = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                check_eq("rst_req", 32'(imem_req_o), 32'd0);
                check_eq("rst_addr", imem_addr_o, 32'd0);
                check_eq("rst_stall", 32'(fetch_stall_o), 32'd0);
                check_eq("rst_ifid_pc", if_id_pc_o, 32'd0);
                check_eq("rst_ifid_instr", if_id_instr_o, NOP_INSTR);
                check_eq("rst_ifid_valid", 32'(if_id_valid_o), 32'd0);
                check_eq("rst_fault", 32'(fetch_fault_o), 32'd0);
                exp_q.delete();
                t_act      = 1'b0;
                f_exp      = 1'b0;
                flush_prev = 1'b0;
                pc_adv     = 1'b0;
                pc_br      = 1'b0;
                pc_i       = start_pc;
            end else begin
                if (pc_br) pc_i = br_pc;
                else if (pc_adv) pc_i = pc_i + 32'd4;
                pc_br  = 1'b0;
                pc_adv = 1'b0;

                check_eq("fetch_stall", 32'(fetch_stall_o), 32'(t_act));
                check_eq("imem_req", 32'(imem_req_o), 32'(t_act && (t_age == 0)));
                if (t_act) check_eq("imem_addr", imem_addr_o, t_pc);
                check_eq("fetch_fault", 32'(fetch_fault_o), 32'(f_exp));
                check_eq("ifid_valid", 32'(if_id_valid_o), 32'(exp_q.size() != 0));
                if (exp_q.size() != 0) begin
                    check_eq("ifid_pc", if_id_pc_o, exp_q[0].pc);
                    check_eq("ifid_instr", if_id_instr_o, exp_q[0].instr);
                end else begin
                    check_eq("bubble_instr", if_id_instr_o, NOP_INSTR);
                end
                if (flush_prev) check_eq("flush_ifid_pc", if_id_pc_o, 32'd0);

                // IF/ID side: consumed by decode or killed by a flush.
                flush_prev = flush_i;
                if (exp_q.size() != 0 && (flush_i || !id_stall_i)) void'(exp_q.pop_front());
                if (flush_i) pc_br = 1'b1;

                // Fetch side.
                if (!t_act) begin
                    if (!flush_i) begin
                        t_act  = 1'b1;
                        t_pc   = pc_i;
                        t_age  = 0;
                        t_resp = 1'b0;
                        t_kill = 1'b0;
                        wc     = 0;
                        pc_adv = 1'b1;
                    end
                end else begin
                    t_age++;
                    if (!t_resp && !t_kill) begin
                        wc++;
                        if (wc >= TIMEOUT) f_exp = 1'b1;
                    end
                    if (imem_valid_i && !t_resp) t_resp = 1'b1;
                    if (flush_i) begin
                        t_kill = 1'b1;
                        if (t_resp) t_act = 1'b0;
                    end else if (t_resp) begin
                        if (t_kill) begin
                            t_act = 1'b0;
                        end else if (!id_stall_i) begin
                            exp_q.push_back('{pc: t_pc, instr: mem_word(t_pc)});
                            t_act = 1'b0;
                        end
                    end
                end
            end
            if (end_req) begin
                $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
                $finish;
            end
        end
    end

    // Main stimulus sequence.
    initial begin
        reset      = 1'b1;
        flush_i    = 1'b0;
        id_stall_i = 1'b0;
        mem_lat    = 1;
        start_pc   = 32'h003F_FFFC;
        br_pc      = '0;
        end_req    = 1'b0;
        cycles(3);
        start_pc = 32'h0040_0000;
        cycles(1);
        reset = 1'b0;

        cycles(8);

        mem_lat = 4;
        cycles(14);

        // Response lands while decode is stalled, then drains from the hold buffer.
        mem_lat = 1;
        cycles(2);
        id_stall_i = 1'b1;
        cycles(3);
        id_stall_i = 1'b0;
        cycles(4);

        // Flush with the response still outstanding; it arrives two cycles later.
        mem_lat = 3;
        cycles(2);
        wait_req();
        flush_i = 1'b1;
        br_pc   = 32'h0040_0100;
        cycles(1);
        flush_i = 1'b0;
        cycles(8);

        // Flush coincident with the response and a decode stall.
        mem_lat = 1;
        cycles(2);
        wait_req();
        flush_i    = 1'b1;
        id_stall_i = 1'b1;
        br_pc      = 32'h0040_0200;
        cycles(1);
        flush_i    = 1'b0;
        id_stall_i = 1'b0;
        cycles(4);

        // Flush while the word sits in the hold buffer.
        wait_req();
        id_stall_i = 1'b1;
        cycles(2);
        flush_i = 1'b1;
        br_pc   = 32'h0040_0300;
        cycles(1);
        flush_i    = 1'b0;
        id_stall_i = 1'b0;
        cycles(4);

        // Memory goes silent: fault after TIMEOUT wait cycles, cleared by reset.
        mem_lat = 0;
        cycles(16);
        reset = 1'b1;
        cycles(2);
        start_pc = 32'h0040_1000;
        cycles(1);
        reset   = 1'b0;
        mem_lat = 1;
        cycles(6);

        end_req = 1'b1;
        cycles(3);
        $display("FAIL end_of_run: monitor did not terminate, %0d tests run, %0d failed",
                 n_run, n_fail);
        $fatal(1, "bench did not terminate");
    end

endmodule
